hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 13 +
 rtl/hazard_match.sv | 48 ++++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared FSM encoding and register constants for hazard_ctrl
package hazard_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    HOLD1 = 2'b01,
    HOLD2 = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - combinational hazard detector returning required stall count N (0..2)
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             id_is_branch_i,
  input  logic [REG_W-1:0] ex_write_reg_i,
  input  logic             ex_reg_write_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] mem_write_reg_i,
  input  logic             mem_mem_read_i,
  output logic [1:0]       n_o
);

  logic rt_src;
  logic ex_hit;
  logic mem_hit;
  logic load_use;
  logic branch_alu;
  logic branch_load_ex;
  logic branch_load_mem;

  // Branches compare both operands in ID, so rt is always a source for them.
  assign rt_src = id_uses_rt_i | id_is_branch_i;

  assign ex_hit = id_valid_i & (ex_write_reg_i != REG_ZERO) &
                  ((ex_write_reg_i == id_rs_i) | (rt_src & (ex_write_reg_i == id_rt_i)));
  assign mem_hit = id_valid_i & (mem_write_reg_i != REG_ZERO) &
                   ((mem_write_reg_i == id_rs_i) | (rt_src & (mem_write_reg_i == id_rt_i)));

  assign load_use        = ex_mem_read_i & ex_reg_write_i & ex_hit;
  assign branch_alu      = id_is_branch_i & ex_reg_write_i & ~ex_mem_read_i & ex_hit;
  assign branch_load_ex  = id_is_branch_i & load_use;
  assign branch_load_mem = id_is_branch_i & mem_mem_read_i & mem_hit;

  always_comb begin
    n_o = 2'd0;
    if (branch_load_ex) begin
      n_o = 2'd2;
    end else if (load_use | branch_alu | branch_load_mem) begin
      n_o = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline stall/flush controller; HAZARD_PERF_EN adds stall/flush counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Freeze,
  input  logic             ID_Valid,
  input  logic [REG_W-1:0] ID_rs,
  input  logic [REG_W-1:0] ID_rt,
  input  logic             ID_UsesRt,
  input  logic             ID_isBranch,
  input  logic             ID_BranchTaken,
  input  logic             ID_isJump,
  input  logic [REG_W-1:0] EX_WriteReg,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] MEM_WriteReg,
  input  logic             MEM_MemRead,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IDEX_Bubble,
  output logic             IFID_Flush
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]      StallCount,
  output logic [31:0]      FlushCount
`endif
);

  hz_state_e state_q, state_d;
  logic [1:0] n_req;
  logic       stall;
  logic       flush;

  hazard_match u_match (
    .id_valid_i      (ID_Valid),
    .id_rs_i         (ID_rs),
    .id_rt_i         (ID_rt),
    .id_uses_rt_i    (ID_UsesRt),
    .id_is_branch_i  (ID_isBranch),
    .ex_write_reg_i  (EX_WriteReg),
    .ex_reg_write_i  (EX_RegWrite),
    .ex_mem_read_i   (EX_MemRead),
    .mem_write_reg_i (MEM_WriteReg),
    .mem_mem_read_i  (MEM_MemRead),
    .n_o             (n_req)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        stall = (n_req != 2'd0);
        if (n_req == 2'd2) state_d = HOLD1;
      end
      HOLD1: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      HOLD2: begin
        stall   = 1'b1;
        state_d = HOLD1;
      end
      default: state_d = IDLE;
    endcase
    if (Freeze) state_d = state_q;
    // Branch outcome only matters once the stall has resolved.
    flush = ~stall & ID_Valid & (ID_isJump | (ID_isBranch & ID_BranchTaken));
  end

  always_comb begin
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    if (!Rst_n) begin
      PCWrite = 1'b1;
    end else if (Freeze) begin
      PCWrite    = 1'b0;
      IFID_Write = 1'b0;
    end else if (stall) begin
      PCWrite     = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Bubble = 1'b1;
    end else begin
      IFID_Flush = flush;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (Rst_n && !Freeze && stall && stall_count_q != 32'hFFFF_FFFF)
      stall_count_d = stall_count_q + 32'd1;
    if (IFID_Flush && flush_count_q != 32'hFFFF_FFFF)
      flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign StallCount = stall_count_q;
  assign FlushCount = flush_count_q;
`endif

endmodule
